// File: rtl/fir_xifu_pkg.sv
// -----------------------------------------------------------------------------
// fir_xifu_pkg
// Shared types for the FIR XIFU issue scoreboard.
//   - fir_xifu_sb_state_e : per-slot lifecycle (FREE / ISSUED / COMMITTED)
//   - fir_xifu_sb_slot_t  : registered contents of one tracker slot
//   - fir_xifu_issue2sb_t : allocator/issue information fanned out to every slot
//   - fir_xifu_sb2issue_t : per-slot status returned to the allocator
// The struct field widths follow the package sizing below; the scoreboard
// parameters default to the same values and must be kept in step with them.
// -----------------------------------------------------------------------------
package fir_xifu_pkg;

    localparam int unsigned FIR_XIFU_NB_REGS     = 4;
    localparam int unsigned FIR_XIFU_ID_WIDTH    = 4;
    localparam int unsigned FIR_XIFU_MAX_INFLIGHT = 4;
    localparam int unsigned FIR_XIFU_RW          = $clog2(FIR_XIFU_NB_REGS);

    typedef logic [FIR_XIFU_ID_WIDTH-1:0] fir_xifu_id_t;
    typedef logic [FIR_XIFU_RW-1:0]       fir_xifu_reg_t;

    typedef enum logic [1:0] {
        SB_FREE      = 2'd0,
        SB_ISSUED    = 2'd1,
        SB_COMMITTED = 2'd2
    } fir_xifu_sb_state_e;

    typedef struct packed {
        fir_xifu_sb_state_e state;
        fir_xifu_id_t       id;
        fir_xifu_reg_t      rd;
        logic               rd_used;
    } fir_xifu_sb_slot_t;

    typedef struct packed {
        logic          alloc;    // this slot takes the offered instruction
        fir_xifu_id_t  id;       // offered id (all slots see it)
        fir_xifu_reg_t rd;
        logic          rd_used;
    } fir_xifu_issue2sb_t;

    typedef struct packed {
        logic          live;        // slot not FREE
        logic          wb_hit;      // writeback targets this slot this cycle
        logic          commit_hit;  // commit targets this slot this cycle
        logic          issue_hit;   // offered id equals this slot's id
        logic          free_nxt;    // FREE now or freed this cycle
        fir_xifu_reg_t rd;
        logic          rd_used;
    } fir_xifu_sb2issue_t;

endpackage

// File: rtl/fir_xifu_sb_slot.sv
// -----------------------------------------------------------------------------
// fir_xifu_sb_slot
// One tracker slot of the FIR XIFU scoreboard: lifecycle FSM plus id match.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   clear_i          synchronous flush to FREE
//   issue_i          allocation strobe and offered instruction fields
//   commit_valid_i / commit_id_i / commit_kill_i   XIF commit interface
//   wb_valid_i / wb_id_i                           regfile writeback
//   sb_o             slot status towards the allocator
// -----------------------------------------------------------------------------
module fir_xifu_sb_slot
    import fir_xifu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  fir_xifu_issue2sb_t issue_i,
    input  logic               commit_valid_i,
    input  fir_xifu_id_t       commit_id_i,
    input  logic               commit_kill_i,
    input  logic               wb_valid_i,
    input  fir_xifu_id_t       wb_id_i,
    output fir_xifu_sb2issue_t sb_o
);

    fir_xifu_sb_slot_t slot_q;

    logic live, wb_hit, commit_hit, kill_hit, free_now;

    always_comb begin
        live       = (slot_q.state != SB_FREE);
        wb_hit     = live & wb_valid_i & (wb_id_i == slot_q.id);
        commit_hit = live & commit_valid_i & (commit_id_i == slot_q.id);
        // A kill only retires an instruction that has not been committed yet.
        kill_hit   = commit_hit & commit_kill_i & (slot_q.state == SB_ISSUED);
        // wb and kill in the same cycle collapse into a single free.
        free_now   = wb_hit | kill_hit;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            slot_q.state   <= SB_FREE;
            slot_q.id      <= '0;
            slot_q.rd      <= '0;
            slot_q.rd_used <= 1'b0;
        end else if (issue_i.alloc) begin
            // Only raised when the slot is FREE or being freed this cycle.
            slot_q.state   <= SB_ISSUED;
            slot_q.id      <= issue_i.id;
            slot_q.rd      <= issue_i.rd;
            slot_q.rd_used <= issue_i.rd_used;
        end else if (free_now) begin
            slot_q.state   <= SB_FREE;
        end else if (commit_hit && !commit_kill_i && slot_q.state == SB_ISSUED) begin
            slot_q.state   <= SB_COMMITTED;
        end
    end

    always_comb begin
        sb_o.live       = live;
        sb_o.wb_hit     = wb_hit;
        sb_o.commit_hit = commit_hit;
        sb_o.issue_hit  = live & (issue_i.id == slot_q.id);
        sb_o.free_nxt   = ~live | free_now;
        sb_o.rd         = slot_q.rd;
        sb_o.rd_used    = slot_q.rd_used;
    end

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// -----------------------------------------------------------------------------
// fir_xifu_scoreboard
// Issue scheduler for the FIR XIFU register file. Tracks every in-flight XIF
// instruction, gates issue_ready_o on RAW/WAW hazards and tracker capacity,
// and frees slots on writeback, commit-kill or clear.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   clear_i             flush all slots
//   issue_*_i           offered instruction (id, rs1, rs2, rd, use bits)
//   issue_ready_o       instruction may be accepted this cycle
//   commit_*_i          XIF commit strobe / id / kill
//   wb_valid_i, wb_id_i XIFU regfile write done
//   busy_o              per-register pending-write mask
//   inflight_o, empty_o occupied slot count, no slot occupied
// Build option: FIR_XIFU_SCOREBOARD_BYPASS_EN lets a same-cycle writeback
// remove its slot's hazard and capacity contribution (0-bubble dependent issue).
// -----------------------------------------------------------------------------
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter int unsigned NB_REGS      = FIR_XIFU_NB_REGS,
    parameter int unsigned ID_WIDTH     = FIR_XIFU_ID_WIDTH,
    parameter int unsigned MAX_INFLIGHT = FIR_XIFU_MAX_INFLIGHT,
    localparam int unsigned RW          = $clog2(NB_REGS),
    localparam int unsigned CW          = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                issue_valid_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [RW-1:0]       issue_rs1_i,
    input  logic [RW-1:0]       issue_rs2_i,
    input  logic [RW-1:0]       issue_rd_i,
    input  logic [2:0]          issue_use_i,
    output logic                issue_ready_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    input  logic                wb_valid_i,
    input  logic [ID_WIDTH-1:0] wb_id_i,
    output logic [NB_REGS-1:0]  busy_o,
    output logic [CW-1:0]       inflight_o,
    output logic                empty_o
);

`ifdef FIR_XIFU_SCOREBOARD_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    fir_xifu_sb2issue_t sb    [MAX_INFLIGHT];
    fir_xifu_issue2sb_t to_sb [MAX_INFLIGHT];

    logic [NB_REGS-1:0] busy_reg, busy_haz;
    logic [CW-1:0]      cnt_reg, cnt_haz;
    logic               full, ready, accept, found;

    // Busy mask and occupancy: registered view for the outputs, and the
    // hazard view that may additionally drop a slot being written back.
    always_comb begin
        busy_reg = '0;
        busy_haz = '0;
        cnt_reg  = '0;
        cnt_haz  = '0;
        for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
            if (sb[i].live) begin
                cnt_reg = cnt_reg + CW'(1);
                if (sb[i].rd_used) busy_reg[sb[i].rd] = 1'b1;
                if (!(BYPASS && sb[i].wb_hit)) begin
                    cnt_haz = cnt_haz + CW'(1);
                    if (sb[i].rd_used) busy_haz[sb[i].rd] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        full   = (cnt_haz == CW'(MAX_INFLIGHT));
        ready  = !rst_i && !clear_i && !full
                 && !(issue_use_i[0] && busy_haz[issue_rs1_i])
                 && !(issue_use_i[1] && busy_haz[issue_rs2_i])
                 && !(issue_use_i[2] && busy_haz[issue_rd_i]);
        accept = issue_valid_i && ready;
    end

    // Lowest-index slot that is free after this cycle's frees takes the instr.
    always_comb begin
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
            to_sb[i].alloc   = accept && !found && sb[i].free_nxt;
            to_sb[i].id      = fir_xifu_id_t'(issue_id_i);
            to_sb[i].rd      = fir_xifu_reg_t'(issue_rd_i);
            to_sb[i].rd_used = issue_use_i[2];
            found            = found | sb[i].free_nxt;
        end
    end

    for (genvar g = 0; g < MAX_INFLIGHT; g++) begin : g_slot
        fir_xifu_sb_slot u_slot (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .clear_i        (clear_i),
            .issue_i        (to_sb[g]),
            .commit_valid_i (commit_valid_i),
            .commit_id_i    (fir_xifu_id_t'(commit_id_i)),
            .commit_kill_i  (commit_kill_i),
            .wb_valid_i     (wb_valid_i),
            .wb_id_i        (fir_xifu_id_t'(wb_id_i)),
            .sb_o           (sb[g])
        );
    end

    assign issue_ready_o = ready;
    assign busy_o        = busy_reg;
    assign inflight_o    = cnt_reg;
    assign empty_o       = (cnt_reg == '0);

`ifndef SYNTHESIS
    logic any_wb_hit, any_commit_hit, any_issue_hit;

    always_comb begin
        any_wb_hit     = 1'b0;
        any_commit_hit = 1'b0;
        any_issue_hit  = 1'b0;
        for (int unsigned i = 0; i < MAX_INFLIGHT; i++) begin
            any_wb_hit     = any_wb_hit     | sb[i].wb_hit;
            any_commit_hit = any_commit_hit | sb[i].commit_hit;
            any_issue_hit  = any_issue_hit  | sb[i].issue_hit;
        end
    end

    a_wb_known:     assert property (@(posedge clk_i) disable iff (rst_i)
                                     wb_valid_i |-> any_wb_hit);
    a_commit_known: assert property (@(posedge clk_i) disable iff (rst_i)
                                     commit_valid_i |-> any_commit_hit);
    a_issue_unique: assert property (@(posedge clk_i) disable iff (rst_i)
                                     accept |-> !any_issue_hit);
`endif

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fir_xifu_scoreboard
// Directed scenarios followed by random traffic. The reference model is a
// queue of in-flight instructions; per-cycle expectations are queued by the
// driver and checked by an independent monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_fir_xifu_scoreboard;

`ifdef FIR_XIFU_SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic       clk;
    logic       rst_i, clear_i, issue_valid_i, commit_valid_i, commit_kill_i, wb_valid_i;
    logic [3:0] issue_id_i, commit_id_i, wb_id_i;
    logic [1:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
    logic [2:0] issue_use_i;
    logic       issue_ready_o, empty_o;
    logic [3:0] busy_o;
    logic [2:0] inflight_o;

    fir_xifu_scoreboard #(.NB_REGS(4), .ID_WIDTH(4), .MAX_INFLIGHT(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .issue_valid_i  (issue_valid_i),
        .issue_id_i     (issue_id_i),
        .issue_rs1_i    (issue_rs1_i),
        .issue_rs2_i    (issue_rs2_i),
        .issue_rd_i     (issue_rd_i),
        .issue_use_i    (issue_use_i),
        .issue_ready_o  (issue_ready_o),
        .commit_valid_i (commit_valid_i),
        .commit_id_i    (commit_id_i),
        .commit_kill_i  (commit_kill_i),
        .wb_valid_i     (wb_valid_i),
        .wb_id_i        (wb_id_i),
        .busy_o         (busy_o),
        .inflight_o     (inflight_o),
        .empty_o        (empty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       rst, clr, iv;
        bit [3:0] id;
        bit [1:0] rs1, rs2, rd;
        bit [2:0] uses;
        bit       cv;
        bit [3:0] cid;
        bit       ck, wv;
        bit [3:0] wid;
    } stim_t;

    typedef struct {
        bit [3:0] id;
        bit [1:0] rd;
        bit       rd_used;
        bit       committed;
    } ent_t;

    typedef struct {
        bit       ready;
        bit [3:0] busy;
        bit [2:0] infl;
        bit       empty;
    } exp_t;

    ent_t live_q[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit id_live(bit [3:0] id);
        foreach (live_q[k]) if (live_q[k].id == id) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle, queue the expected outputs, advance the model.
    task automatic apply(input stim_t s, output bit acc);
        exp_t     e;
        bit [3:0] hz;
        int       hn;
        ent_t     ne;
        int       k;
        @(posedge clk);
        #1;
        rst_i = s.rst; clear_i = s.clr; issue_valid_i = s.iv; issue_id_i = s.id;
        issue_rs1_i = s.rs1; issue_rs2_i = s.rs2; issue_rd_i = s.rd; issue_use_i = s.uses;
        commit_valid_i = s.cv; commit_id_i = s.cid; commit_kill_i = s.ck;
        wb_valid_i = s.wv; wb_id_i = s.wid;

        e.busy = '0; hz = '0; hn = 0;
        foreach (live_q[j]) begin
            if (live_q[j].rd_used) e.busy[live_q[j].rd] = 1'b1;
            if (!(BYPASS && s.wv && live_q[j].id == s.wid)) begin
                hn++;
                if (live_q[j].rd_used) hz[live_q[j].rd] = 1'b1;
            end
        end
        e.infl  = 3'(live_q.size());
        e.empty = (live_q.size() == 0);
        e.ready = !s.rst && !s.clr && (hn < 4)
                  && !(s.uses[0] && hz[s.rs1]) && !(s.uses[1] && hz[s.rs2])
                  && !(s.uses[2] && hz[s.rd]);
        exp_q.push_back(e);
        acc = s.iv && e.ready;

        if (s.rst || s.clr) begin
            live_q.delete();
        end else begin
            if (s.wv) begin
                k = -1;
                foreach (live_q[j]) if (live_q[j].id == s.wid) k = j;
                if (k >= 0) live_q.delete(k);
            end
            if (s.cv) begin
                k = -1;
                foreach (live_q[j]) if (live_q[j].id == s.cid) k = j;
                if (k >= 0 && !live_q[k].committed) begin
                    if (s.ck) live_q.delete(k);
                    else      live_q[k].committed = 1'b1;
                end
            end
            if (acc) begin
                ne.id = s.id; ne.rd = s.rd; ne.rd_used = s.uses[2]; ne.committed = 1'b0;
                live_q.push_back(ne);
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: one expectation record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_ready", int'(issue_ready_o), int'(e.ready));
            chk("busy",        int'(busy_o),        int'(e.busy));
            chk("inflight",    int'(inflight_o),    int'(e.infl));
            chk("empty",       int'(empty_o),       int'(e.empty));
        end
    end

    task automatic issue(input bit [3:0] id, input bit [1:0] rs1, input bit [1:0] rd,
                         input bit [2:0] uses, output bit acc);
        stim_t s;
        s = nop(); s.iv = 1; s.id = id; s.rs1 = rs1; s.rs2 = 2'd0; s.rd = rd; s.uses = uses;
        apply(s, acc);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) apply(nop(), acc);
    endtask

    task automatic drain();
        stim_t s;
        bit    acc;
        for (int i = 0; i < 8 && live_q.size() > 0; i++) begin
            s = nop(); s.wv = 1; s.wid = live_q[0].id;
            apply(s, acc);
        end
        idle(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        bit    acc;
        int    k;

        rst_i = 1; clear_i = 0; issue_valid_i = 0; issue_id_i = 0; issue_rs1_i = 0;
        issue_rs2_i = 0; issue_rd_i = 0; issue_use_i = 0; commit_valid_i = 0;
        commit_id_i = 0; commit_kill_i = 0; wb_valid_i = 0; wb_id_i = 0;

        // 1: reset then idle
        s = nop(); s.rst = 1;
        apply(s, acc); apply(s, acc);
        idle(2);

        // 2: RAW on rd=2, released by wb of id 1
        issue(4'd1, 2'd0, 2'd2, 3'b100, acc);
        for (int i = 0; i < 3; i++) issue(4'd2, 2'd2, 2'd0, 3'b001, acc);
        s = nop(); s.iv = 1; s.id = 4'd2; s.rs1 = 2'd2; s.uses = 3'b001; s.wv = 1; s.wid = 4'd1;
        apply(s, acc);
        for (int i = 0; i < 3 && !acc; i++) issue(4'd2, 2'd2, 2'd0, 3'b001, acc);
        drain();

        // 3: fill all slots, then free one with wb
        for (int i = 0; i < 4; i++) issue(4'(i), 2'd0, 2'(i), 3'b100, acc);
        for (int i = 0; i < 2; i++) issue(4'd4, 2'd0, 2'd2, 3'b100, acc);
        s = nop(); s.iv = 1; s.id = 4'd4; s.rd = 2'd2; s.uses = 3'b100; s.wv = 1; s.wid = 4'd2;
        apply(s, acc);
        for (int i = 0; i < 3 && !acc; i++) issue(4'd4, 2'd0, 2'd2, 3'b100, acc);
        drain();

        // 4: kill without writeback
        issue(4'd5, 2'd0, 2'd1, 3'b100, acc);
        s = nop(); s.cv = 1; s.cid = 4'd5; s.ck = 1;
        apply(s, acc);
        idle(2);

        // 5: wb and kill of the same id in one cycle
        issue(4'd6, 2'd0, 2'd3, 3'b100, acc);
        s = nop(); s.cv = 1; s.cid = 4'd6; s.ck = 1; s.wv = 1; s.wid = 4'd6;
        apply(s, acc);
        idle(2);

        // 6: clear with an instruction offered
        for (int i = 0; i < 3; i++) issue(4'(7 + i), 2'd3, 2'(i), 3'b100, acc);
        s = nop(); s.clr = 1; s.iv = 1; s.id = 4'd10; s.rd = 2'd3; s.uses = 3'b100;
        apply(s, acc);
        idle(2);

        // 7: reset pulse mid-operation
        issue(4'd11, 2'd0, 2'd0, 3'b100, acc);
        issue(4'd12, 2'd0, 2'd1, 3'b101, acc);
        s = nop(); s.rst = 1;
        apply(s, acc);
        idle(2);

        // Random traffic with legal commit/wb ids
        for (int n = 0; n < 2500; n++) begin
            s = nop();
            s.iv = ($urandom_range(0, 9) < 6);
            do s.id = 4'($urandom); while (id_live(s.id));
            s.rs1 = 2'($urandom); s.rs2 = 2'($urandom); s.rd = 2'($urandom);
            s.uses = 3'($urandom);
            if (live_q.size() > 0 && $urandom_range(0, 9) < 4) begin
                k = $urandom_range(0, live_q.size() - 1);
                if (!live_q[k].committed) begin
                    s.cv = 1; s.cid = live_q[k].id; s.ck = ($urandom_range(0, 3) == 0);
                end
            end
            if (live_q.size() > 0 && $urandom_range(0, 99) < 35) begin
                k = $urandom_range(0, live_q.size() - 1);
                s.wv = 1; s.wid = live_q[k].id;
            end
            s.clr = ($urandom_range(0, 99) == 0);
            s.rst = ($urandom_range(0, 199) == 0);
            apply(s, acc);
        end
        drain();

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
